cache_req_arb: RTL and testbench

//  Two-requester front-end arbiter for the cache controller upstream port (p0).

---
 rtl/cache_req_arb.sv | 162 ++++++++++++++++
 tb/tb_cache_req_arb.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_req_arb.sv
// rtl/cache_req_arb.sv - two-requester p0 arbiter with in-order read response routing
// Optional feature macro: CACHE_ARB_FIXED_PRIO_EN (requester 0 always wins ties instead of round-robin).
module cache_req_arb #(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int WMASK_WIDTH = 4,
   parameter int MAX_OUTST   = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         r0_vld_i,
   output logic                         r0_rdy_o,
   input  logic [ADDR_WIDTH-1:0]        r0_addr_i,
   input  logic                         r0_web_i,
   input  logic [DATA_WIDTH-1:0]        r0_wdat_i,
   input  logic [WMASK_WIDTH-1:0]       r0_wmask_i,
   output logic                         r0_dvld_o,
   input  logic                         r0_drdy_i,
   output logic [DATA_WIDTH-1:0]        r0_ddat_o,
   input  logic                         r1_vld_i,
   output logic                         r1_rdy_o,
   input  logic [ADDR_WIDTH-1:0]        r1_addr_i,
   input  logic                         r1_web_i,
   input  logic [DATA_WIDTH-1:0]        r1_wdat_i,
   input  logic [WMASK_WIDTH-1:0]       r1_wmask_i,
   output logic                         r1_dvld_o,
   input  logic                         r1_drdy_i,
   output logic [DATA_WIDTH-1:0]        r1_ddat_o,
   output logic                         c_uvld_o,
   input  logic                         c_urdy_i,
   output logic [ADDR_WIDTH-1:0]        c_addr_o,
   output logic                         c_web_o,
   output logic [DATA_WIDTH-1:0]        c_wdat_o,
   output logic [WMASK_WIDTH-1:0]       c_wmask_o,
   input  logic                         c_dvld_i,
   output logic                         c_drdy_o,
   input  logic [DATA_WIDTH-1:0]        c_ddat_i,
   output logic [$clog2(MAX_OUTST):0]   outst_o,
   output logic                         err_o
);
   localparam int PW = $clog2(MAX_OUTST);
   localparam int CW = PW + 1;

   logic [MAX_OUTST-1:0] route_q;
   logic [PW-1:0]        wptr_q;
   logic [PW-1:0]        rptr_q;
   logic [CW-1:0]        count_q;
   logic                 lock_q;
   logic                 lock_gnt_q;
   logic                 err_q;
`ifndef CACHE_ARB_FIXED_PRIO_EN
   logic                 rr_last_q;
`endif

   logic gnt;
   logic gnt_vld;
   logic stall;
   logic accept;
   logic push;
   logic pop;
   logic empty;
   logic full;
   logic head;

   // A locked grant stays put until the controller takes the held request.
   always_comb begin
      gnt = 1'b0;
      if (lock_q) begin
         gnt = lock_gnt_q;
      end else if (r0_vld_i && r1_vld_i) begin
`ifdef CACHE_ARB_FIXED_PRIO_EN
         gnt = 1'b0;
`else
         gnt = ~rr_last_q;
`endif
      end else if (r1_vld_i) begin
         gnt = 1'b1;
      end
   end

   always_comb begin
      if (gnt) begin
         gnt_vld   = r1_vld_i;
         c_addr_o  = r1_addr_i;
         c_web_o   = r1_web_i;
         c_wdat_o  = r1_wdat_i;
         c_wmask_o = r1_wmask_i;
      end else begin
         gnt_vld   = r0_vld_i;
         c_addr_o  = r0_addr_i;
         c_web_o   = r0_web_i;
         c_wdat_o  = r0_wdat_i;
         c_wmask_o = r0_wmask_i;
      end
   end

   assign empty    = (count_q == '0);
   assign full     = (count_q == CW'(MAX_OUTST));
   // Uses registered fullness only, so a same-cycle pop cannot release a stalled read.
   assign stall    = c_web_o && full;
   assign c_uvld_o = gnt_vld && !stall;
   assign r0_rdy_o = !gnt && c_urdy_i && !stall;
   assign r1_rdy_o =  gnt && c_urdy_i && !stall;
   assign accept   = c_uvld_o && c_urdy_i;
   assign push     = accept && c_web_o;

   assign head      = route_q[rptr_q];
   assign r0_dvld_o = c_dvld_i && !empty && !head;
   assign r1_dvld_o = c_dvld_i && !empty &&  head;
   assign c_drdy_o  = !empty && (head ? r1_drdy_i : r0_drdy_i);
   assign r0_ddat_o = c_ddat_i;
   assign r1_ddat_o = c_ddat_i;
   assign pop       = c_dvld_i && c_drdy_o;

   assign outst_o = count_q;
   assign err_o   = err_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         route_q    <= '0;
         wptr_q     <= '0;
         rptr_q     <= '0;
         count_q    <= '0;
         lock_q     <= 1'b0;
         lock_gnt_q <= 1'b0;
         err_q      <= 1'b0;
`ifndef CACHE_ARB_FIXED_PRIO_EN
         rr_last_q  <= 1'b1;
`endif
      end else begin
         if (push) begin
            route_q[wptr_q] <= gnt;
            wptr_q          <= wptr_q + PW'(1);
         end
         if (pop) begin
            rptr_q <= rptr_q + PW'(1);
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
         if (accept) begin
            lock_q <= 1'b0;
         end else if (c_uvld_o) begin
            lock_q <= 1'b1;
         end
         if (!lock_q) begin
            lock_gnt_q <= gnt;
         end
`ifndef CACHE_ARB_FIXED_PRIO_EN
         if (accept) begin
            rr_last_q <= gnt;
         end
`endif
         // A beat with nothing to route is left unconsumed and flagged.
         if (c_dvld_i && empty) begin
            err_q <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_cache_req_arb.sv
// tb/tb_cache_req_arb.sv - self-checking bench for cache_req_arb against a transaction-level model
module tb_cache_req_arb;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int MW = 4;
   localparam int MO = 4;
`ifdef CACHE_ARB_FIXED_PRIO_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [1:0]    vld = '0;
   logic [1:0]    web = '0;
   logic [1:0]    drdy = '0;
   logic [AW-1:0] addr [2];
   logic [DW-1:0] wdat [2];
   logic [MW-1:0] wmask [2];
   logic          urdy = 1'b0;
   logic          dvld = 1'b0;
   logic [DW-1:0] ddat = '0;

   logic          r0_rdy_o, r1_rdy_o, r0_dvld_o, r1_dvld_o;
   logic [DW-1:0] r0_ddat_o, r1_ddat_o;
   logic          c_uvld_o, c_web_o, c_drdy_o, err_o;
   logic [AW-1:0] c_addr_o;
   logic [DW-1:0] c_wdat_o;
   logic [MW-1:0] c_wmask_o;
   logic [2:0]    outst_o;

   int passed = 0;
   int fails  = 0;
   int total  = 0;

   // model: owners of outstanding reads in issue order, last accepted requester, held grant
   int   q[$];
   int   last;
   int   held;
   bit   err_m;
   bit [1:0] acc;

   cache_req_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WMASK_WIDTH(MW), .MAX_OUTST(MO)) dut (
      .clk(clk), .reset(reset),
      .r0_vld_i(vld[0]), .r0_rdy_o(r0_rdy_o), .r0_addr_i(addr[0]), .r0_web_i(web[0]),
      .r0_wdat_i(wdat[0]), .r0_wmask_i(wmask[0]), .r0_dvld_o(r0_dvld_o), .r0_drdy_i(drdy[0]),
      .r0_ddat_o(r0_ddat_o),
      .r1_vld_i(vld[1]), .r1_rdy_o(r1_rdy_o), .r1_addr_i(addr[1]), .r1_web_i(web[1]),
      .r1_wdat_i(wdat[1]), .r1_wmask_i(wmask[1]), .r1_dvld_o(r1_dvld_o), .r1_drdy_i(drdy[1]),
      .r1_ddat_o(r1_ddat_o),
      .c_uvld_o(c_uvld_o), .c_urdy_i(urdy), .c_addr_o(c_addr_o), .c_web_o(c_web_o),
      .c_wdat_o(c_wdat_o), .c_wmask_o(c_wmask_o), .c_dvld_i(dvld), .c_drdy_o(c_drdy_o),
      .c_ddat_i(ddat), .outst_o(outst_o), .err_o(err_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b0; vld = '0; dvld = 1'b0; urdy = 1'b0; drdy = '0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      q.delete(); last = 1; held = -1; err_m = 1'b0; acc = '0;
   endtask

   // Checks one cycle of DUT outputs against the model, then advances the model and the clock.
   task automatic step();
      int g, h;
      bit ue, ne;
      logic [1:0] rdy_obs;
      #1;
      ne = (q.size() != 0);
      h  = ne ? q[0] : 0;
      if (held >= 0)          g = held;
      else if (vld == 2'b11)  g = FIXED ? 0 : 1 - last;
      else if (vld[1])        g = 1;
      else                    g = 0;
      ue = vld[g] && !(web[g] && q.size() == MO);
      check("c_uvld", c_uvld_o, ue);
      if (ue) begin
         check("c_addr", c_addr_o, addr[g]);
         check("c_web", c_web_o, web[g]);
         check("c_wdat", c_wdat_o, wdat[g]);
         check("c_wmask", c_wmask_o, wmask[g]);
      end
      rdy_obs = {r1_rdy_o, r0_rdy_o};
      for (int n = 0; n < 2; n++) begin
         acc[n] = (n == g) && ue && urdy;
         check($sformatf("accept%0d", n), vld[n] & rdy_obs[n], acc[n]);
      end
      check("r0_dvld", r0_dvld_o, dvld && ne && h == 0);
      check("r1_dvld", r1_dvld_o, dvld && ne && h == 1);
      check("c_drdy", c_drdy_o, ne && drdy[h]);
      if (dvld) begin
         check("r0_ddat", r0_ddat_o, ddat);
         check("r1_ddat", r1_ddat_o, ddat);
      end
      check("outst", outst_o, q.size());
      check("err", err_o, err_m);
      if (dvld && !ne) err_m = 1'b1;
      if (dvld && ne && drdy[h]) void'(q.pop_front());
      if (acc[g]) begin
         last = g; held = -1;
         if (web[g]) q.push_back(g);
      end else if (ue) begin
         held = g;
      end
      @(negedge clk);
   endtask

   task automatic drain();
      vld = '0; drdy = 2'b11;
      for (int i = 0; i < 2 * MO && q.size() != 0; i++) begin
         dvld = 1'b1; ddat = $urandom;
         step();
      end
      dvld = 1'b0;
      check("drained", outst_o, 0);
   endtask

   initial begin
      int g, prev;
      for (int n = 0; n < 2; n++) begin
         addr[n] = '0; wdat[n] = '0; wmask[n] = '0;
      end

      // reset state and first-grant priority
      do_reset();
      #1;
      check("rst_outst", outst_o, 0);
      check("rst_err", err_o, 0);
      check("rst_drdy", c_drdy_o, 0);
      check("rst_dvld", {r1_dvld_o, r0_dvld_o}, 0);
      vld = 2'b11; web = 2'b11; urdy = 1'b1;
      #1;
      check("rst_prio_r0", r0_rdy_o, 1);
      check("rst_prio_r1", r1_rdy_o, 0);
      vld = '0; urdy = 1'b0;
      step();

      // 1: single read and its response
      vld = 2'b01; addr[0] = 32'h100; web[0] = 1'b1; urdy = 1'b1;
      step();
      check("t1_outst1", outst_o, 1);
      vld = '0; dvld = 1'b1; ddat = 32'hDEAD; drdy = 2'b01;
      #1;
      check("t1_r0_dvld", r0_dvld_o, 1);
      check("t1_r0_ddat", r0_ddat_o, 32'hDEAD);
      step();
      dvld = 1'b0;
      check("t1_outst0", outst_o, 0);

      // 2: both requesters reading continuously
      vld = 2'b11; web = 2'b11; urdy = 1'b1; drdy = 2'b11; prev = 0;
      for (int i = 0; i < 6; i++) begin
         dvld = (q.size() != 0); ddat = $urandom;
         addr[0] = $urandom; addr[1] = $urandom;
         step();
         g = acc[1] ? 1 : 0;
         check("t2_issued", acc != 2'b00, 1);
         check("t2_grant", g, FIXED ? 0 : 1 - prev);
         prev = g;
      end
      drain();

      // 3: lock held on r1 while the controller stalls
      vld = 2'b10; web[1] = 1'b1; addr[1] = 32'h300; urdy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (i == 1) begin vld[0] = 1'b1; web[0] = 1'b1; addr[0] = 32'h200; end
         #1;
         check("t3_addr", c_addr_o, 32'h300);
         check("t3_r0_rdy", r0_rdy_o, 0);
         step();
      end
      urdy = 1'b1;
      step();
      check("t3_r1_acc", acc, 2'b10);
      vld[1] = 1'b0;
      step();
      check("t3_r0_acc", acc, 2'b01);
      drain();

      // 4: route FIFO full stalls reads, writes still pass
      urdy = 1'b1; vld = 2'b01; web[0] = 1'b1;
      for (int i = 0; i < MO; i++) begin
         addr[0] = 32'h400 + 32'(i * 4);
         step();
      end
      check("t4_full", outst_o, MO);
      vld = 2'b10; web[1] = 1'b1; addr[1] = 32'h500;
      #1;
      check("t4_stall", c_uvld_o, 0);
      step();
      vld = 2'b01; web[0] = 1'b0; addr[0] = 32'h600; wdat[0] = 32'hCAFE; wmask[0] = 4'hF;
      #1;
      check("t4_write_rdy", r0_rdy_o, 1);
      step();
      vld = 2'b10; dvld = 1'b1; drdy = 2'b01; ddat = 32'h1111;
      #1;
      check("t4_pop_stall", c_uvld_o, 0);
      step();
      dvld = 1'b0;
      #1;
      check("t4_resume", c_uvld_o, 1);
      step();
      drain();

      // 5: interleaved reads and a write, r0 back-pressures its beat
      urdy = 1'b1;
      vld = 2'b01; web[0] = 1'b1; addr[0] = 32'h700; step();
      vld = 2'b10; web[1] = 1'b0; addr[1] = 32'h704; wdat[1] = 32'h55; step();
      vld = 2'b10; web[1] = 1'b1; addr[1] = 32'h708; step();
      vld = '0;
      check("t5_outst", outst_o, 2);
      dvld = 1'b1; drdy = 2'b10; ddat = 32'hB1;
      for (int i = 0; i < 2; i++) begin
         #1;
         check("t5_hold_drdy", c_drdy_o, 0);
         check("t5_hold_dvld", r0_dvld_o, 1);
         step();
      end
      drdy = 2'b11;
      step();
      ddat = 32'hB2;
      #1;
      check("t5_beat2_r1", r1_dvld_o, 1);
      step();
      dvld = 1'b0;
      check("t5_done", outst_o, 0);

      // randomized traffic against the model
      acc = '0;
      for (int c = 0; c < 1500; c++) begin
         for (int n = 0; n < 2; n++) begin
            if (!vld[n] || acc[n]) begin
               vld[n]   = ($urandom_range(2) != 0);
               addr[n]  = $urandom;
               web[n]   = ($urandom_range(2) != 0);
               wdat[n]  = $urandom;
               wmask[n] = MW'($urandom);
            end
         end
         urdy = ($urandom_range(3) != 0);
         dvld = (q.size() != 0) && ($urandom_range(1) != 0);
         ddat = $urandom;
         drdy = 2'($urandom);
         step();
      end
      for (int i = 0; i < 8 && held >= 0; i++) begin
         urdy = 1'b1;
         step();
      end
      drain();

      // 6: response with nothing outstanding
      vld = '0; dvld = 1'b1; drdy = 2'b11; ddat = 32'hBAD;
      #1;
      check("t6_drdy", c_drdy_o, 0);
      step();
      dvld = 1'b0;
      check("t6_err_set", err_o, 1);
      step();
      step();
      check("t6_err_held", err_o, 1);
      do_reset();
      #1;
      check("t6_err_clr", err_o, 0);
      check("t6_outst_clr", outst_o, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
